// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the HEX status display.
package hex_disp_pkg;

    localparam int unsigned DIGITS = 6;
    localparam int unsigned KEY_W  = 24;

    // Digit codes 0..15 are hex nibbles; these two are the extra glyphs.
    localparam logic [4:0] CODE_DASH  = 5'd16;
    localparam logic [4:0] CODE_BLANK = 5'd17;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StFound = 2'd2,
        StFail  = 2'd3
    } disp_state_e;

endpackage

// File: rtl/segger7.sv
// Active-low 7-segment decoder, bit order {g,f,e,d,c,b,a}.
// Codes 0..15 give hex glyphs, 16 a dash, anything else blank.
module segger7 (
    input  logic [4:0] code_i,
    output logic [6:0] seg_o
);

    // Glyph lookup.
    always_comb begin
        seg_o = 7'b1111111;
        case (code_i)
            5'd0:    seg_o = 7'b1000000;
            5'd1:    seg_o = 7'b1111001;
            5'd2:    seg_o = 7'b0100100;
            5'd3:    seg_o = 7'b0110000;
            5'd4:    seg_o = 7'b0011001;
            5'd5:    seg_o = 7'b0010010;
            5'd6:    seg_o = 7'b0000010;
            5'd7:    seg_o = 7'b1111000;
            5'd8:    seg_o = 7'b0000000;
            5'd9:    seg_o = 7'b0010000;
            5'd10:   seg_o = 7'b0001000;
            5'd11:   seg_o = 7'b0000011;
            5'd12:   seg_o = 7'b1000110;
            5'd13:   seg_o = 7'b0100001;
            5'd14:   seg_o = 7'b0000110;
            5'd15:   seg_o = 7'b0001110;
            5'd16:   seg_o = 7'b0111111;
            default: seg_o = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/tick_gen.sv
// Free-running divider: pulses tick on the last count of each DIV-cycle period.
// The counter sits at zero whenever it is cleared or disabled.
module tick_gen #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count and wrap pulse.
    always_comb begin
        tick  = en && (cnt_q == CntMax);
        cnt_d = cnt_q;
        if (clr || !en) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hex_status_display_ctrl.sv
// Six-digit HEX status display for the ARC4 key search.
// Optional build macro FOUND_BLINK_EN: blink the found key with half-period BLINK_DIV.
module hex_status_display_ctrl
    import hex_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 5_000_000,
    parameter int unsigned BLINK_DIV   = 25_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_live,
    input  logic             found_valid,
    input  logic [KEY_W-1:0] key_found,
    input  logic             fail,
    output logic [6:0]       HEX5,
    output logic [6:0]       HEX4,
    output logic [6:0]       HEX3,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX0,
    output logic [1:0]       state_o
);

    if (REFRESH_DIV < 2) begin : g_bad_refresh_div
        $error("REFRESH_DIV must be at least 2");
    end
    if (BLINK_DIV < 2) begin : g_bad_blink_div
        $error("BLINK_DIV must be at least 2");
    end

    disp_state_e      state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [4:0]       code_q [DIGITS];
    logic [4:0]       code_d [DIGITS];
    logic             refresh_tick;
    logic             show_key;

    // Live-key sampling period; restarted by start and parked at zero outside RUN.
    tick_gen #(
        .DIV (REFRESH_DIV)
    ) u_refresh (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == StRun),
        .clr  (start || (state_d != StRun)),
        .tick (refresh_tick)
    );

`ifdef FOUND_BLINK_EN
    logic blink_tick;
    logic visible_q, visible_d;

    tick_gen #(
        .DIV (BLINK_DIV)
    ) u_blink (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == StFound),
        .clr  (state_d != StFound),
        .tick (blink_tick)
    );

    // Visible on entry to FOUND, toggled at every blink wrap.
    always_comb begin
        visible_d = visible_q;
        if ((state_d == StFound) && (state_q != StFound)) begin
            visible_d = 1'b1;
        end else if (blink_tick) begin
            visible_d = ~visible_q;
        end
    end

    // Blink flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            visible_q <= 1'b1;
        end else begin
            visible_q <= visible_d;
        end
    end

    assign show_key = visible_d;
`else
    assign show_key = 1'b1;
`endif

    // Search status and displayed key; start outranks found, found outranks fail.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        if (start) begin
            state_d = StRun;
            key_d   = key_live;
        end else if (state_q == StRun) begin
            if (found_valid) begin
                state_d = StFound;
                key_d   = key_found;
            end else if (fail) begin
                state_d = StFail;
            end else if (refresh_tick) begin
                key_d = key_live;
            end
        end
    end

    // Digit codes follow the next state so HEX changes with no extra latency.
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            code_d[i] = CODE_BLANK;
            unique case (state_d)
                StIdle:  code_d[i] = CODE_BLANK;
                StRun:   code_d[i] = {1'b0, key_d[4*i +: 4]};
                StFound: code_d[i] = show_key ? {1'b0, key_d[4*i +: 4]} : CODE_BLANK;
                StFail:  code_d[i] = CODE_DASH;
            endcase
        end
    end

    // State, key and code registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            key_q   <= '0;
            for (int i = 0; i < DIGITS; i++) begin
                code_q[i] <= CODE_BLANK;
            end
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            for (int i = 0; i < DIGITS; i++) begin
                code_q[i] <= code_d[i];
            end
        end
    end

    assign state_o = state_q;

    segger7 u_seg5 (.code_i(code_q[5]), .seg_o(HEX5));
    segger7 u_seg4 (.code_i(code_q[4]), .seg_o(HEX4));
    segger7 u_seg3 (.code_i(code_q[3]), .seg_o(HEX3));
    segger7 u_seg2 (.code_i(code_q[2]), .seg_o(HEX2));
    segger7 u_seg1 (.code_i(code_q[1]), .seg_o(HEX1));
    segger7 u_seg0 (.code_i(code_q[0]), .seg_o(HEX0));

endmodule

// File: tb/tb_hex_status_display_ctrl.sv
// Scoreboard bench for hex_status_display_ctrl with a behavioural display model.
module tb_hex_status_display_ctrl;

    localparam int unsigned RD = 4;
    localparam int unsigned BD = 3;

    logic        clk = 1'b0;
    logic        rst, start, found_valid, fail;
    logic [23:0] key_live, key_found;
    logic [6:0]  hex5, hex4, hex3, hex2, hex1, hex0;
    logic [1:0]  state_o;

    hex_status_display_ctrl #(
        .REFRESH_DIV (RD),
        .BLINK_DIV   (BD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .key_live    (key_live),
        .found_valid (found_valid),
        .key_found   (key_found),
        .fail        (fail),
        .HEX5        (hex5),
        .HEX4        (hex4),
        .HEX3        (hex3),
        .HEX2        (hex2),
        .HEX1        (hex1),
        .HEX0        (hex0),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  st;
        logic [41:0] hex;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: 0 idle, 1 searching, 2 found, 3 failed.
    int          m_st     = 0;
    logic [23:0] m_key    = '0;
    int          m_since  = 0;
    int          m_fsince = 0;
    logic [23:0] kl       = '0;

    function automatic logic [6:0] seg_of(input int c);
        case (c)
            0:  return 7'h40;
            1:  return 7'h79;
            2:  return 7'h24;
            3:  return 7'h30;
            4:  return 7'h19;
            5:  return 7'h12;
            6:  return 7'h02;
            7:  return 7'h78;
            8:  return 7'h00;
            9:  return 7'h10;
            10: return 7'h08;
            11: return 7'h03;
            12: return 7'h46;
            13: return 7'h21;
            14: return 7'h06;
            15: return 7'h0E;
            16: return 7'h3F;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        bit   shown;
        e.st  = m_st[1:0];
        e.hex = '0;
        shown = 1'b1;
`ifdef FOUND_BLINK_EN
        if (m_st == 2) shown = ((m_fsince / BD) % 2) == 0;
`endif
        for (int i = 5; i >= 0; i--) begin
            int c;
            if (m_st == 0) c = 17;
            else if (m_st == 3) c = 16;
            else if (m_st == 2 && !shown) c = 17;
            else c = int'((m_key >> (4 * i)) & 24'hF);
            e.hex = {e.hex[34:0], seg_of(c)};
        end
        return e;
    endfunction

    // Advance the model across one clock edge with the given inputs.
    task automatic model_edge(input bit r, input bit s, input logic [23:0] l, input bit fv,
                              input logic [23:0] kf, input bit fl);
        if (r) begin
            m_st  = 0;
            m_key = '0;
        end else if (s) begin
            m_st    = 1;
            m_key   = l;
            m_since = 0;
        end else if (m_st == 1 && fv) begin
            m_st     = 2;
            m_key    = kf;
            m_fsince = 0;
        end else if (m_st == 1 && fl) begin
            m_st = 3;
        end else if (m_st == 1) begin
            m_since++;
            if (m_since % RD == 0) m_key = l;
        end else if (m_st == 2) begin
            m_fsince++;
        end
    endtask

    // Drive one cycle; expected result is queued once the edge has happened.
    task automatic cyc(input bit r, input bit s, input bit fv, input logic [23:0] kf,
                       input bit fl);
        rst         = r;
        start       = s;
        key_live    = kl;
        found_valid = fv;
        key_found   = kf;
        fail        = fl;
        model_edge(r, s, kl, fv, kf, fl);
        @(posedge clk);
        sb.push_back(expect_now());
        #1;
        kl = kl + 24'd1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, $urandom, 1'b0);
    endtask

    // Monitor: outputs are valid every cycle after an edge.
    exp_t mon_e;
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if (state_o !== mon_e.st) begin
                errors++;
                $display("FAIL state_o at %0t: got %0d want %0d", $time, state_o, mon_e.st);
            end
            checks++;
            if ({hex5, hex4, hex3, hex2, hex1, hex0} !== mon_e.hex) begin
                errors++;
                $display("FAIL hex at %0t: got %h want %h (st %0d)", $time,
                         {hex5, hex4, hex3, hex2, hex1, hex0}, mon_e.hex, mon_e.st);
            end
        end
    end

    initial begin
        // Reset then idle.
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
        idle(10);

        // Start with a counting live key; next sample four cycles later.
        kl = 24'h00001A;
        cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
        idle(9);

        // Found, then a fail pulse that must be ignored.
        cyc(1'b0, 1'b0, 1'b1, 24'h3C5A7F, 1'b0);
        idle(5);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
        idle(3);

        // Fail, then a found pulse that must be ignored.
        cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
        idle(3);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 24'h123456, 1'b0);
        idle(3);

        // Simultaneous events and reset during RUN.
        cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
        idle(2);
        cyc(1'b0, 1'b0, 1'b1, 24'h654321, 1'b1);
        idle(2);
        cyc(1'b0, 1'b1, 1'b1, 24'h777777, 1'b0);
        idle(2);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
        idle(2);

        // Found key display (blinks when the blink build is enabled), restart mid-blank.
        cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
        idle(2);
        cyc(1'b0, 1'b0, 1'b1, 24'hABCDEF, 1'b0);
        idle(4);
        cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
        idle(3);
        cyc(1'b0, 1'b0, 1'b1, 24'h0F1E2D, 1'b0);
        idle(12);

        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            kl = $urandom;
            cyc($urandom_range(99) == 0, $urandom_range(19) == 0,
                $urandom_range(14) == 0, $urandom, $urandom_range(24) == 0);
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d left want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
